// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding and
// the processor register values that signal a finished test.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        DONE
    } state_t;

    localparam logic [31:0] ECALL_EXIT = 32'd93;
    localparam logic [31:0] PASS_VALUE = 32'd1;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; wordValid is a
// combinational one-cycle pulse on the handshake that delivers the 4th byte.
module byte_word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byteValid,
    input  logic [7:0]  byteData,
    output logic        wordValid,
    output logic [31:0] word
);

    logic [1:0]  idx_q;
    logic [23:0] asm_q;

    // The top byte is never stored: it is taken straight from the bus so the
    // completed word is available on the same edge that accepts it.
    assign wordValid = byteValid && (idx_q == 2'd3);
    assign word      = {byteData, asm_q};

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            idx_q <= '0;
        end else if (byteValid) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (byteValid) begin
            case (idx_q)
                2'd0:    asm_q[7:0]   <= byteData;
                2'd1:    asm_q[15:8]  <= byteData;
                2'd2:    asm_q[23:16] <= byteData;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a test program into the processor's instruction memory, then runs it
// out of reset and reports pass, fail or timeout from x17/x3.
module program_loader
    import loader_pkg::*;
#(
    parameter int MEM_DEPTH      = 512,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17,
    localparam int WC_W          = $clog2(MEM_DEPTH) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            byteValid,
    input  logic [7:0]      byteData,
    output logic            byteReady,
    output logic            insMemEn,
    output logic [31:0]     insMemAddr,
    output logic [31:0]     insMemDataIn,
    output logic            cpuReset,
    input  logic [31:0]     exitReg,
    input  logic [31:0]     resultReg,
    output logic [WC_W-1:0] wordCount,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout
);

    state_t           state_q, state_d;
    logic             accept;
    logic             asm_clear;
    logic             word_valid;
    logic [31:0]      word;
    logic             last_slot;
    logic             exit_hit;
    logic             run_expired;
    logic [CNT_W-1:0] run_cnt_q;

    assign byteReady   = (state_q == LOAD);
    assign accept      = byteValid && byteReady;
    assign asm_clear   = (state_q == IDLE) || (state_q == DONE);
    assign last_slot   = (wordCount == WC_W'(MEM_DEPTH - 1));
    assign exit_hit    = (exitReg == ECALL_EXIT);
    assign run_expired = (run_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    assign cpuReset = (state_q != RUN);
    assign busy     = (state_q == LOAD) || (state_q == RELEASE) || (state_q == RUN);
    assign done     = (state_q == DONE);

    byte_word_assembler u_asm (
        .clock     (clock),
        .reset     (reset),
        .clear     (asm_clear),
        .byteValid (accept),
        .byteData  (byteData),
        .wordValid (word_valid),
        .word      (word)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                // The final slot's write happens during RELEASE, which keeps
                // the processor in reset until that write has landed.
                if (word_valid && ((word == 32'd0) || last_slot)) state_d = RELEASE;
            end
            RELEASE: state_d = RUN;
            RUN: begin
                if (exit_hit || run_expired) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            insMemEn     <= 1'b0;
            insMemAddr   <= '0;
            insMemDataIn <= '0;
            wordCount    <= '0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            run_cnt_q    <= '0;
        end else begin
            insMemEn <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        wordCount <= '0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (word_valid && (word != 32'd0)) begin
                        insMemEn     <= 1'b1;
                        insMemAddr   <= 32'(wordCount);
                        insMemDataIn <= word;
                        wordCount    <= wordCount + WC_W'(1);
                    end
                end
                RELEASE: run_cnt_q <= '0;
                RUN: begin
                    run_cnt_q <= run_cnt_q + CNT_W'(1);
                    if (exit_hit) begin
                        pass    <= (resultReg == PASS_VALUE);
                        timeout <= 1'b0;
                    end else if (run_expired) begin
                        pass    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized scoreboard bench for program_loader: a word-level program model
// predicts memory writes and run outcomes; a monitor checks them as they occur.
module tb_program_loader;

    localparam int MEM_DEPTH = 512;
    localparam int TO        = 20;
    localparam int CNT_W     = 5;
    localparam int WC_W      = $clog2(MEM_DEPTH) + 1;

    logic            clock;
    logic            reset;
    logic            start;
    logic            byteValid;
    logic [7:0]      byteData;
    logic            byteReady;
    logic            insMemEn;
    logic [31:0]     insMemAddr;
    logic [31:0]     insMemDataIn;
    logic            cpuReset;
    logic [31:0]     exitReg;
    logic [31:0]     resultReg;
    logic [WC_W-1:0] wordCount;
    logic            busy;
    logic            done;
    logic            pass;
    logic            timeout;

    program_loader #(
        .MEM_DEPTH      (MEM_DEPTH),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .byteValid    (byteValid),
        .byteData     (byteData),
        .byteReady    (byteReady),
        .insMemEn     (insMemEn),
        .insMemAddr   (insMemAddr),
        .insMemDataIn (insMemDataIn),
        .cpuReset     (cpuReset),
        .exitReg      (exitReg),
        .resultReg    (resultReg),
        .wordCount    (wordCount),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic pass_e;
        logic to_e;
    } res_t;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    wr_t        wq[$];
    res_t       rq[$];
    logic [7:0] bytes_q[$];

    // Program model: little-endian words, zero terminates, MEM_DEPTH words max.
    int          m_widx;
    int          m_pos;
    logic [31:0] m_word;
    bit          m_fin;
    int          last_cyc;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every write strobe and every completion against the queues.
    logic prev_done = 1'b0;
    always @(negedge clock) begin
        wr_t  w;
        res_t r;
        if (insMemEn === 1'b1) begin
            if (wq.size() == 0) begin
                chk("spurious_write", 32'd1, 32'd0);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", insMemAddr, w.addr);
                chk("wr_data", insMemDataIn, w.data);
                chk("wr_cycle", 32'(cyc), 32'(w.cyc));
            end
        end
        if (done === 1'b1 && prev_done === 1'b0) begin
            if (rq.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                r = rq.pop_front();
                chk("result_pass", {31'd0, pass}, {31'd0, r.pass_e});
                chk("result_timeout", {31'd0, timeout}, {31'd0, r.to_e});
            end
        end
        prev_done = done;
    end

    task automatic model_start();
        m_widx = 0;
        m_pos  = 0;
        m_word = '0;
        m_fin  = 1'b0;
        bytes_q.delete();
    endtask

    task automatic model_accept(input logic [7:0] b, input int wcyc);
        wr_t w;
        m_word[8*m_pos +: 8] = b;
        m_pos++;
        if (m_pos == 4) begin
            m_pos = 0;
            if (m_word == 32'd0) begin
                m_fin = 1'b1;
            end else begin
                w.addr = 32'(m_widx);
                w.data = m_word;
                w.cyc  = wcyc;
                wq.push_back(w);
                m_widx++;
                if (m_widx == MEM_DEPTH) m_fin = 1'b1;
            end
            m_word = '0;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        bytes_q.push_back(w[7:0]);
        bytes_q.push_back(w[15:8]);
        bytes_q.push_back(w[23:16]);
        bytes_q.push_back(w[31:24]);
    endtask

    function automatic logic [31:0] rand_nz();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'd0) w = 32'd1;
        return w;
    endfunction

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Feed bytes_q until the model says loading ended or max_bytes were accepted.
    task automatic stream(input int max_bytes, input bit gaps);
        int acc = 0;
        int guard = 0;
        logic [7:0] b;
        while (bytes_q.size() > 0 && !m_fin && (max_bytes < 0 || acc < max_bytes)
               && guard < 20000) begin
            @(negedge clock);
            guard++;
            byteValid = 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) continue;
            byteValid = 1'b1;
            byteData  = bytes_q[0];
            if (byteReady) begin
                b = bytes_q.pop_front();
                acc++;
                model_accept(b, cyc + 1);
                if (m_fin) last_cyc = cyc;
            end
        end
        if (guard >= 20000) chk("stream_budget", 32'd1, 32'd0);
    endtask

    // Keep offering bytes after loading ends; none may be taken before RUN.
    task automatic wait_run(input int exp_words);
        int extra = 0;
        int t = 0;
        while (t < 50) begin
            @(negedge clock);
            t++;
            if (cyc == last_cyc + 1) begin
                chk("release_cpureset", {31'd0, cpuReset}, 32'd1);
                chk("release_byteready", {31'd0, byteReady}, 32'd0);
            end
            if (cpuReset == 1'b0) break;
            byteValid = 1'b1;
            byteData  = 8'($urandom);
            if (byteReady) extra++;
        end
        byteValid = 1'b0;
        chk("run_entry_cycle", 32'(cyc), 32'(last_cyc + 2));
        chk("extra_bytes_taken", 32'(extra), 32'd0);
        chk("word_count", 32'(wordCount), 32'(exp_words));
    endtask

    // Drive x17/x3 during RUN; exit_at < 0 or >= TO means no exit before timeout.
    task automatic run_prog(input int exit_at, input logic [31:0] res, input bit start_pulse);
        res_t r;
        int   len;
        int   k = 0;
        if (exit_at >= 0 && exit_at < TO) begin
            len      = exit_at + 1;
            r.pass_e = (res == 32'd1);
            r.to_e   = 1'b0;
        end else begin
            len      = TO;
            r.pass_e = 1'b0;
            r.to_e   = 1'b1;
        end
        rq.push_back(r);
        resultReg = res;
        while (k < TO + 5) begin
            exitReg = (k == exit_at) ? 32'd93 : 32'($urandom_range(0, 92));
            start   = start_pulse && (k == 2);
            @(negedge clock);
            start = 1'b0;
            k++;
            if (done) break;
            if (start_pulse && k == 3) chk("start_ignored_run", {31'd0, cpuReset}, 32'd0);
        end
        exitReg = 32'd0;
        chk("run_length", 32'(k), 32'(len));
        chk("done_cpureset", {31'd0, cpuReset}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic random_session(input int nwords, input int exit_at, input logic [31:0] res);
        pulse_start();
        model_start();
        for (int i = 0; i < nwords; i++) push_word(rand_nz());
        push_word(32'd0);
        stream(-1, 1'b1);
        wait_run(nwords);
        run_prog(exit_at, res, 1'b0);
    endtask

    initial begin
        logic [7:0] prog1[12];
        reset = 1'b1; start = 1'b0; byteValid = 1'b0; byteData = '0;
        exitReg = '0; resultReg = '0;
        repeat (3) @(negedge clock);
        chk("rst_byteready", {31'd0, byteReady}, 32'd0);
        chk("rst_insmemen", {31'd0, insMemEn}, 32'd0);
        chk("rst_addr", insMemAddr, 32'd0);
        chk("rst_data", insMemDataIn, 32'd0);
        chk("rst_cpureset", {31'd0, cpuReset}, 32'd1);
        chk("rst_wordcount", 32'(wordCount), 32'd0);
        chk("rst_flags", {28'd0, busy, done, pass, timeout}, 32'd0);
        reset = 1'b0;

        // Two-instruction program from the plan, exit with pass.
        prog1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start();
        model_start();
        foreach (prog1[i]) bytes_q.push_back(prog1[i]);
        stream(-1, 1'b0);
        wait_run(2);
        run_prog(3, 32'd1, 1'b0);

        // Fail result, with gaps in the stream and a start pulse during RUN.
        pulse_start();
        model_start();
        for (int i = 0; i < 4; i++) push_word(rand_nz());
        push_word(32'd0);
        stream(-1, 1'b1);
        wait_run(4);
        run_prog(6, 32'd5, 1'b1);

        // Full memory without terminator, then a timeout.
        pulse_start();
        model_start();
        for (int i = 0; i < MEM_DEPTH; i++) push_word(rand_nz());
        push_word(rand_nz());
        stream(-1, 1'b1);
        wait_run(MEM_DEPTH);
        run_prog(-1, 32'd1, 1'b0);

        // Exit in the final timeout cycle beats the timeout.
        random_session(1, TO - 1, 32'd1);

        // Reset mid-word after six bytes, then a clean session from IDLE.
        pulse_start();
        model_start();
        push_word(rand_nz());
        push_word(rand_nz());
        push_word(32'd0);
        stream(6, 1'b0);
        @(negedge clock);
        byteValid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_cpureset", {31'd0, cpuReset}, 32'd1);
        chk("abort_wordcount", 32'(wordCount), 32'd0);
        chk("abort_insmemen", {31'd0, insMemEn}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_pending_writes", 32'(wq.size()), 32'd0);
        random_session(3, 2, 32'd1);

        for (int s = 0; s < 4; s++) begin
            random_session($urandom_range(1, 12), $urandom_range(0, TO + 4),
                           ($urandom_range(0, 1) == 1) ? 32'd1 : $urandom);
        end

        repeat (3) @(negedge clock);
        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("results_outstanding", 32'(rq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Sits directly upstream of `processor`.
- Accepts a little-endian byte stream of a test program and assembles 32-bit words.
- Drives the processor's instruction-memory write port (`insMemEn` / `insMemAddr` / `insMemDataIn`) and holds the processor in reset until loading completes.
- After releasing reset, it monitors the exit register (x17) and the test-result register (x3), then reports pass, fail or timeout.

Parameters:
- MEM_DEPTH, 512, instruction-memory depth in 32-bit words; maximum words loaded.
- TIMEOUT_CYCLES, 100000, cycles allowed in RUN before a timeout is declared.
- CNT_W, 17, width of the run-cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  — single clock; all logic on the rising edge.
- reset  in  1  — synchronous, active-high; returns the block to IDLE.
- start  in  1  — single-cycle pulse; begins a load session from IDLE or DONE.
- byteValid  in  1  — stream byte valid.
- byteData  in  8  — stream byte.
- byteReady  out  1  — loader accepts a byte when byteValid && byteReady.
- insMemEn  out  1  — instruction-memory write strobe, one cycle per word.
- insMemAddr  out  32  — word index being written.
- insMemDataIn  out  32  — word being written.
- cpuReset  out  1  — drives `processor` reset; high except in RUN.
- exitReg  in  32  — processor register x17.
- resultReg  in  32  — processor register x3.
- wordCount  out  $clog2(MEM_DEPTH)+1  — number of words written this session.
- busy  out  1  — high in LOAD, RELEASE and RUN.
- done  out  1  — high in DONE.
- pass  out  1  — valid while done.
- timeout  out  1  — valid while done.

Behaviour:
- Reset values: byteReady=0, insMemEn=0, insMemAddr=0, insMemDataIn=0, cpuReset=1, wordCount=0, busy=0, done=0, pass=0, timeout=0.
  - Reset mid-session aborts immediately to IDLE.
  - A partial word is discarded.
- States: IDLE, LOAD, RELEASE, RUN, DONE.
- IDLE:
  - byteReady=0, cpuReset=1.
  - start -> LOAD. Clear byte index, word index, wordCount, pass and timeout.
- LOAD:
  - byteReady=1.
  - Each accepted byte is placed at bits [8*k+7:8*k] of the assembly register, where k is the byte index 0..3.
  - On the 4th byte the assembled word is complete.
    - Word == 0: terminator. No write occurs; go to RELEASE on the next edge.
    - Otherwise: register the word. In the following cycle, insMemEn=1, insMemAddr=word index, insMemDataIn=word. Word index and wordCount increment on that edge.
  - byteReady stays 1 during the write cycle. Bytes accepted then go to the new assembly word; the output data register is separate from the assembly register.
  - After the write with word index MEM_DEPTH-1, go to RELEASE. Stream bytes are then not accepted.
  - byteValid low simply stalls; there is no timeout in LOAD.
- RELEASE:
  - Lasts exactly one cycle with cpuReset=1 and byteReady=0.
  - Guarantees the last write lands before the processor leaves reset.
  - Go to RUN and clear the run counter.
- RUN:
  - cpuReset=0. The counter increments every cycle.
  - exitReg == 93 (ecall exit): pass = (resultReg == 1), timeout=0, go to DONE.
  - Otherwise, if counter == TIMEOUT_CYCLES-1: pass=0, timeout=1, go to DONE.
  - If both occur in the same cycle, the exit check wins.
- DONE:
  - cpuReset=1, done=1. pass and timeout hold.
  - start -> LOAD as from IDLE.
- start is ignored in LOAD, RELEASE and RUN.
- insMemEn is never high outside the cycle following word completion in LOAD.
- Latency: 4th byte accepted at edge N gives insMemEn high in cycle N+1. A terminator accepted at edge N gives RELEASE in cycle N+1 and cpuReset low in cycle N+2.

Decomposition:
- Package `loader_pkg`:
  - state enum (IDLE, LOAD, RELEASE, RUN, DONE);
  - constants ECALL_EXIT=32'd93 and PASS_VALUE=32'd1.
- Sub-module `byte_word_assembler`:
  - takes byte valid/data and a clear input;
  - outputs wordValid (1-cycle pulse) and a 32-bit word;
  - contains the 2-bit byte index and the assembly register.
- The FSM, write-port registers and run counter stay in `program_loader`.

Test Plan:
1. Stream bytes 13 00 00 00 93 00 10 00 00 00 00 00 after start -> two writes: addr 0 data 0x00000013, then addr 1 data 0x00100093. wordCount=2, RELEASE then cpuReset=0.
2. In RUN, drive exitReg=93 with resultReg=1 -> next cycle done=1, pass=1, timeout=0, cpuReset=1. Repeat with resultReg=5 -> pass=0.
3. Send 512 nonzero words with no terminator -> 512 writes to addr 0..511 and byteReady=0 afterwards. Extra bytes are not accepted; RUN is entered.
4. Hold exitReg=0 in RUN with TIMEOUT_CYCLES=20 -> done after exactly 20 RUN cycles with timeout=1, pass=0. exitReg=93 in that same final cycle -> timeout=0.
5. Assert reset after 6 bytes of a session -> next cycle IDLE, cpuReset=1, wordCount=0, no spurious insMemEn. A new start plus a fresh stream writes addr 0 correctly.
6. Pulse start during RUN and drop byteValid mid-word in LOAD -> start has no effect. The stall produces no write, and the word completes correctly once bytes resume.
